fetch_unit_v: RTL and testbench

FETCH_UNIT_V -- requirements
Module: fetch_unit_v

---
 rtl/fetch_unit_v.sv | 83 ++++++++
 tb/tb_fetch_unit_v.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit_v.sv
// fetch_unit_v: single-outstanding instruction fetch with IF/ID register, stall skid and flush drain
module fetch_unit_v #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
    state_t      state;
    logic [31:0] pc, skid_pc, skid_instr, redir, tgt;
    assign tgt       = target & 32'hFFFF_FFFC;
    assign imem_req  = !rst && state != HOLD;
    assign imem_addr = pc;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            skid_pc    <= '0;
            skid_instr <= '0;
            redir      <= '0;
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
        end else if (flush) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            // an unacked request must still complete, so park the redirect and drain it
            if (state != HOLD && !imem_ack) begin
                redir <= tgt;
                state <= DRAIN;
            end else begin
                pc    <= tgt;
                state <= FETCH;
            end
        end else begin
            case (state)
                FETCH:
                    if (imem_ack && stall) begin
                        skid_pc    <= pc;
                        skid_instr <= imem_rdata;
                        state      <= HOLD;
                    end else if (imem_ack) begin
                        ifid_valid <= 1'b1;
                        ifid_pc    <= pc;
                        ifid_instr <= imem_rdata;
                        pc         <= pc + 32'd4;
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                        ifid_instr <= NOP_INSTR;
                    end
                HOLD:
                    if (!stall) begin
                        ifid_valid <= 1'b1;
                        ifid_pc    <= skid_pc;
                        ifid_instr <= skid_instr;
                        pc         <= pc + 32'd4;
                        state      <= FETCH;
                    end
                DRAIN: begin
                    ifid_valid <= 1'b0;
                    ifid_instr <= NOP_INSTR;
                    if (imem_ack) begin
                        pc    <= redir;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit_v.sv
// tb_fetch_unit_v: directed stimulus with a scoreboard of expected IF/ID entries
module tb_fetch_unit_v;
    logic        clk = 0, rst = 1, stall = 0, flush = 0, imem_ack = 0;
    logic [31:0] target = 0, imem_rdata = 0;
    logic        imem_req, ifid_valid;
    logic [31:0] imem_addr, ifid_pc, ifid_instr;
    int          checks = 0, errors = 0;
    logic [63:0] exp_q[$];

    fetch_unit_v dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .target(target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
        .ifid_instr(ifid_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic ack, input logic st, input logic fl, input logic [31:0] tg);
        @(negedge clk);
        rst = r; imem_ack = ack; stall = st; flush = fl; target = tg;
        imem_rdata = ack ? mem(imem_addr) : 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    task automatic chk_bubble(input string name);
        chk({name, "_valid"}, {31'b0, ifid_valid}, 32'd0);
        chk({name, "_instr"}, ifid_instr, 32'h0000_0013);
    endtask

    // monitor: a valid IF/ID after an edge with stall=0 and rst=0 is a fresh load
    always @(posedge clk) begin
        logic s, r;
        logic [63:0] e;
        s = stall; r = rst;
        #1;
        if (!r && !s && ifid_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ifid: got pc %h instr %h expected none", ifid_pc, ifid_instr);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", ifid_pc, e[63:32]);
                chk("sb_instr", ifid_instr, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_ifid_pc", ifid_pc, 32'd0);
        chk_bubble("rst");
        @(negedge clk);
        rst = 0;
        #1;
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        // zero-wait streaming
        push(32'h0, 32'h1000_0000); step(0, 1, 0, 0, 0);
        push(32'h4, 32'h1000_0004); step(0, 1, 0, 0, 0);
        push(32'h8, 32'h1000_0008); step(0, 1, 0, 0, 0);
        push(32'hC, 32'h1000_000C); step(0, 1, 0, 0, 0);
        chk("stream_addr", imem_addr, 32'h10);
        // two-cycle ack latency
        step(0, 0, 0, 0, 0);
        chk_bubble("lat1"); chk("lat1_addr", imem_addr, 32'h10);
        step(0, 0, 0, 0, 0);
        chk_bubble("lat2"); chk("lat2_addr", imem_addr, 32'h10);
        push(32'h10, 32'h1000_0010); step(0, 1, 0, 0, 0);
        // stall coincident with ack
        push(32'h14, 32'h1000_0014); step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, i == 0, 1, 0, 0);
            chk("hold_req", {31'b0, imem_req}, 32'd0);
            chk("hold_pc", ifid_pc, 32'h14);
            chk("hold_valid", {31'b0, ifid_valid}, 32'd1);
        end
        push(32'h18, 32'h1000_0018); step(0, 0, 0, 0, 0);
        chk("unhold_req", {31'b0, imem_req}, 32'd1);
        chk("unhold_addr", imem_addr, 32'h1C);
        // flush with request pending -> drain
        step(0, 0, 0, 1, 32'h0000_0103);
        chk_bubble("drain1"); chk("drain1_addr", imem_addr, 32'h1C); chk("drain1_pc", ifid_pc, 32'd0);
        step(0, 0, 1, 0, 0);
        chk_bubble("drain2"); chk("drain2_addr", imem_addr, 32'h1C);
        step(0, 1, 0, 0, 0);
        chk_bubble("drain3"); chk("drain3_addr", imem_addr, 32'h100);
        push(32'h100, 32'h1000_0100); step(0, 1, 0, 0, 0);
        // second flush in drain with ack uses the newer target
        step(0, 0, 0, 1, 32'h200);
        step(0, 1, 0, 1, 32'h307);
        chk_bubble("reflush"); chk("reflush_addr", imem_addr, 32'h304);
        push(32'h304, 32'h1000_0304); step(0, 1, 0, 0, 0);
        // flush and stall together with ack
        step(0, 1, 1, 1, 32'h40);
        chk_bubble("fl_st"); chk("fl_st_pc", ifid_pc, 32'd0);
        chk("fl_st_addr", imem_addr, 32'h40); chk("fl_st_req", {31'b0, imem_req}, 32'd1);
        push(32'h40, 32'h1000_0040); step(0, 1, 0, 0, 0);
        // pc wrap
        step(0, 1, 0, 1, 32'hFFFF_FFFF);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, 32'h0FFF_FFFC); step(0, 1, 0, 0, 0);
        chk("wrap_addr1", imem_addr, 32'h0);
        push(32'h0, 32'h1000_0000); step(0, 1, 0, 0, 0);
        // flush in hold discards skid
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 32'h80);
        chk_bubble("hold_fl"); chk("hold_fl_addr", imem_addr, 32'h80);
        push(32'h80, 32'h1000_0080); step(0, 1, 0, 0, 0);
        // reset while in hold, acks ignored during reset
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("rh_req", {31'b0, imem_req}, 32'd0); chk("rh_pc", ifid_pc, 32'd0); chk_bubble("rh");
        step(1, 1, 0, 0, 0);
        chk("rh2_pc", ifid_pc, 32'd0); chk_bubble("rh2");
        @(negedge clk);
        rst = 0; imem_ack = 0; stall = 0;
        #1;
        chk("rel_req", {31'b0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'd0);
        push(32'h0, 32'h1000_0000); step(0, 1, 0, 0, 0);
        chk("rel_next_addr", imem_addr, 32'h4);
        repeat (3) step(0, 0, 0, 0, 0);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
